unidade_busca: RTL

- Instruction-fetch front end of the nRisc core; the initiator side of the instruction-memory read interface.
- Issues 8-bit addresses (`label`) to the instruction memory, which registers `Memo[label]` on each posedge and presents it on `instrucao` one cycle later.
- Captures each returned word into an instruction register for decode.
- Handles sequential increment with wrap, decode stalls, taken branches (flushing the in-flight word) and a HALT opcode.

---
 rtl/unidade_busca.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/unidade_busca.sv
// -----------------------------------------------------------------------------
// unidade_busca -- instruction-fetch front end of the nRisc core.
//
// Drives the read address of a synchronous instruction memory (the memory
// registers Memo[label] on every posedge and shows it on `instrucao` one cycle
// later) and captures each returned word into an instruction register.
//
// Ports:
//   clk            system clock, all state changes on posedge
//   reset          asynchronous, active-low reset
//   label          [7:0] combinational read address to instruction memory
//   instrucao      [7:0] memory data = Memo[label sampled at previous posedge]
//   stall          decode cannot accept a new word this cycle
//   branch_taken   instruction in `ir` redirects the PC to branch_target
//   branch_target  [7:0] redirect address, valid with branch_taken
//   ir             [7:0] instruction register
//   ir_pc          [7:0] address of the word held in `ir`
//   ir_valid       `ir` holds a live instruction
//   halted         HALT opcode reached; fetch frozen until reset (FSM state)
//   addr_err       one-cycle pulse when branch_target >= MEM_DEPTH
//
// Flow control: `stall` is the decode-side "not ready". A word in `ir` with
// ir_valid=1 is consumed on every posedge where stall=0; while stall=1 all
// fetch state holds and the memory keeps re-reading the in-flight address so
// `instrucao` stays valid for the held word. branch_taken overrides stall.
// -----------------------------------------------------------------------------
module unidade_busca #(
  parameter int         MEM_DEPTH   = 30,
  parameter logic [7:0] RESET_PC    = 8'd0,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] label,
  input  logic [7:0] instrucao,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic [7:0] ir,
  output logic [7:0] ir_pc,
  output logic       ir_valid,
  output logic       halted,
  output logic       addr_err
);

  localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);
  localparam logic [8:0] DEPTH9    = 9'(MEM_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_f_addr, w_f_addr_nxt;
  logic       r_f_valid, w_f_valid_nxt;
  logic [7:0] r_ir, w_ir_nxt;
  logic [7:0] r_ir_pc, w_ir_pc_nxt;
  logic       r_ir_valid, w_ir_valid_nxt;
  logic       r_addr_err, w_addr_err_nxt;

  logic       w_tgt_oob;
  logic [7:0] w_tgt;
  logic [7:0] w_label;

  // Sequential increment that wraps at the end of the memory image.
  function automatic logic [7:0] inc(input logic [7:0] x);
    return (x == LAST_ADDR) ? 8'd0 : x + 8'd1;
  endfunction

  // Out-of-range branch targets are redirected to address 0.
  assign w_tgt_oob = ({1'b0, branch_target} >= DEPTH9);
  assign w_tgt     = w_tgt_oob ? 8'd0 : branch_target;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_f_addr_nxt   = r_f_addr;
    w_f_valid_nxt  = r_f_valid;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_ir_valid_nxt = r_ir_valid;
    w_addr_err_nxt = 1'b0;
    w_label        = r_pc;

    case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          // Redirect: the word arriving now is discarded, the target is
          // fetched this edge and pc moves past it.
          w_label        = w_tgt;
          w_f_addr_nxt   = w_tgt;
          w_f_valid_nxt  = 1'b1;
          w_pc_nxt       = inc(w_tgt);
          w_ir_valid_nxt = 1'b0;
          w_addr_err_nxt = w_tgt_oob;
        end else if (stall) begin
          // Re-read the in-flight word so it is still on instrucao next cycle.
          w_label = r_f_addr;
        end else begin
          w_label        = r_pc;
          w_ir_nxt       = instrucao;
          w_ir_pc_nxt    = r_f_addr;
          w_ir_valid_nxt = r_f_valid;
          w_f_addr_nxt   = r_pc;
          if (r_f_valid && (instrucao == HALT_OPCODE)) begin
            // HALT still goes into ir; nothing behind it is live.
            w_f_valid_nxt = 1'b0;
            w_state_nxt   = ST_HALT;
          end else begin
            w_f_valid_nxt = 1'b1;
            w_pc_nxt      = inc(r_pc);
          end
        end
      end
      ST_HALT: begin
        w_label = r_f_addr;
        if (!stall) w_ir_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_f_addr   <= RESET_PC;
      r_f_valid  <= 1'b0;
      r_ir       <= 8'd0;
      r_ir_pc    <= 8'd0;
      r_ir_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_f_addr   <= w_f_addr_nxt;
      r_f_valid  <= w_f_valid_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

  assign label    = w_label;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = (r_state == ST_HALT);
  assign addr_err = r_addr_err;

endmodule
